mips_run_monitor: RTL and testbench

MIPS_RUN_MONITOR -- requirements
Module: mips_run_monitor

---
 rtl/mips_pkg.sv | 20 ++
 rtl/mips_exp_fifo.sv | 74 +++++++
 rtl/mips_run_monitor.sv | 172 +++++++++++++++++
 tb/tb_mips_run_monitor.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS run monitor: FSM states, register-address width
// and the default writeback data width.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } mon_state_e;

  function automatic logic is_terminal(input mon_state_e s);
    return s inside {ST_PASS, ST_FAIL, ST_TIMEOUT};
  endfunction

endpackage

// File: rtl/mips_exp_fifo.sv
// Expected-writeback queue: DEPTH entries of {reg addr, data}. An explicit occupancy
// count keeps full and empty unambiguous when the pointers are equal.
module mips_exp_fifo
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  output logic [REG_ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0]     head_data,
  output logic                  full,
  output logic                  empty,
  output logic                  empty_next
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int ENT_W = REG_ADDR_W + DATA_W;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign full       = (level_q == LVL_FULL);
  assign empty      = (level_q == '0);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign empty_next = (level_d == '0);
  assign {head_addr, head_data} = mem_q[rd_ptr_q];

  // NOTE: every signal written here gets a default first, so no path holds a value and infers a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is not reset; clearing the pointers and level is what discards old entries.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {push_addr, push_data};
  end

endmodule

// File: rtl/mips_run_monitor.sv
// Run monitor: sequences the core reset, checks observed register writebacks against a
// queue of expected writes, and reports a sticky PASS / FAIL / TIMEOUT verdict.
module mips_run_monitor
  import mips_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = 8,
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 80,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  core_rst_n,
  input  logic                  exp_valid,
  output logic                  exp_ready,
  input  logic [REG_ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0]     exp_data,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  end_of_test,
  output logic [CNT_W-1:0]      cycle_count,
  output logic [CNT_W-1:0]      mismatch_count,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [REG_ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0]     fail_exp,
  output logic [DATA_W-1:0]     fail_got
);

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [CNT_W-1:0]  CYC_LIMIT = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  mon_state_e            state_q, state_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic                  core_rst_n_q, core_rst_n_d;
  logic [CNT_W-1:0]      cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0]      mismatch_count_q, mismatch_count_d;
  logic                  done_q, done_d, pass_q, pass_d;
  logic                  fail_q, fail_d, timeout_q, timeout_d;
  logic [REG_ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0]     fail_exp_q, fail_exp_d, fail_got_q, fail_got_d;

  logic                  push, pop, wb_fire, mismatch;
  logic                  fifo_full, fifo_empty, fifo_empty_next;
  logic [REG_ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0]     head_data;

  // Pushes are accepted during HOLD so the expected stream can be preloaded.
  assign exp_ready = reset && !fifo_full && !is_terminal(state_q);
  assign push      = exp_valid && exp_ready;
  assign wb_fire   = (state_q == ST_RUN) && wb_valid;
  assign pop       = wb_fire && !fifo_empty;
  // An empty queue means the core wrote something nobody expected.
  assign mismatch  = wb_fire && (fifo_empty || head_addr != wb_addr || head_data != wb_data);

  mips_exp_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_exp_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_addr  (exp_addr),
    .push_data  (exp_data),
    .pop        (pop),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .empty_next (fifo_empty_next)
  );

  always_comb begin
    state_d          = state_q;
    hold_cnt_d       = hold_cnt_q;
    core_rst_n_d     = core_rst_n_q;
    cycle_count_d    = cycle_count_q;
    mismatch_count_d = mismatch_count_q;
    done_d           = done_q;
    pass_d           = pass_q;
    fail_d           = fail_q;
    timeout_d        = timeout_q;
    fail_addr_d      = fail_addr_q;
    fail_exp_d       = fail_exp_q;
    fail_got_d       = fail_got_q;
    unique case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          core_rst_n_d = 1'b1;
          state_d      = ST_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end
      end
      ST_RUN: begin
        if (cycle_count_q != '1) cycle_count_d = cycle_count_q + CNT_ONE;
        if (mismatch) begin
          if (mismatch_count_q != '1) mismatch_count_d = mismatch_count_q + CNT_ONE;
          if (mismatch_count_q == '0) begin
            fail_addr_d = fifo_empty ? '0 : head_addr;
            fail_exp_d  = fifo_empty ? '0 : head_data;
            fail_got_d  = wb_data;
          end
        end
        if (cycle_count_q == CYC_LIMIT) begin
          state_d   = ST_TIMEOUT;
          timeout_d = 1'b1;
          fail_d    = 1'b1;
        end else if (end_of_test) begin
          if (!mismatch && mismatch_count_q == '0 && fifo_empty_next) begin
            state_d = ST_PASS;
            pass_d  = 1'b1;
          end else begin
            state_d = ST_FAIL;
            fail_d  = 1'b1;
          end
        end
        if (state_d != ST_RUN) begin
          done_d       = 1'b1;
          core_rst_n_d = 1'b0;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_HOLD;
      hold_cnt_q       <= '0;
      core_rst_n_q     <= 1'b0;
      cycle_count_q    <= '0;
      mismatch_count_q <= '0;
      done_q           <= 1'b0;
      pass_q           <= 1'b0;
      fail_q           <= 1'b0;
      timeout_q        <= 1'b0;
      fail_addr_q      <= '0;
      fail_exp_q       <= '0;
      fail_got_q       <= '0;
    end else begin
      state_q          <= state_d;
      hold_cnt_q       <= hold_cnt_d;
      core_rst_n_q     <= core_rst_n_d;
      cycle_count_q    <= cycle_count_d;
      mismatch_count_q <= mismatch_count_d;
      done_q           <= done_d;
      pass_q           <= pass_d;
      fail_q           <= fail_d;
      timeout_q        <= timeout_d;
      fail_addr_q      <= fail_addr_d;
      fail_exp_q       <= fail_exp_d;
      fail_got_q       <= fail_got_d;
    end
  end

  assign core_rst_n     = core_rst_n_q;
  assign cycle_count    = cycle_count_q;
  assign mismatch_count = mismatch_count_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign fail           = fail_q;
  assign timeout        = timeout_q;
  assign fail_addr      = fail_addr_q;
  assign fail_exp       = fail_exp_q;
  assign fail_got       = fail_got_q;

endmodule

// File: tb/tb_mips_run_monitor.sv
// Bench for mips_run_monitor: directed scenarios plus randomized traffic checked against a
// queue-based model of the monitor's verdict rules.
module tb_mips_run_monitor;

  localparam int DATA_W     = 32;
  localparam int DEPTH      = 8;
  localparam int RST_CYCLES = 2;
  localparam int MAX_CYCLES = 80;
  localparam int CNT_W      = 16;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;
  localparam int P_HOLD = 0, P_RUN = 1, P_PASS = 2, P_FAIL = 3, P_TIMEOUT = 4;

  logic              clk = 1'b1;
  logic              reset = 1'b0;
  logic              exp_valid = 1'b0;
  logic [4:0]        exp_addr = '0;
  logic [DATA_W-1:0] exp_data = '0;
  logic              wb_valid = 1'b0;
  logic [4:0]        wb_addr = '0;
  logic [DATA_W-1:0] wb_data = '0;
  logic              end_of_test = 1'b0;
  logic              core_rst_n, exp_ready, done, pass, fail, timeout;
  logic [CNT_W-1:0]  cycle_count, mismatch_count;
  logic [4:0]        fail_addr;
  logic [DATA_W-1:0] fail_exp, fail_got;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the run is a phase, a count of run cycles, a count of mismatches
  // and a queue of outstanding expected writes.
  int                m_phase = P_HOLD;
  int                m_hold = 0;
  int                m_cycles = 0;
  int                m_mis = 0;
  logic [36:0]       m_q[$];
  logic [4:0]        m_faddr = '0;
  logic [DATA_W-1:0] m_fexp = '0, m_fgot = '0;

  mips_run_monitor #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .RST_CYCLES(RST_CYCLES),
    .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .core_rst_n(core_rst_n),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_addr(exp_addr), .exp_data(exp_data),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .end_of_test(end_of_test),
    .cycle_count(cycle_count), .mismatch_count(mismatch_count),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_got(fail_got)
  );

  always #5 clk = ~clk;

  function automatic bit m_ready();
    return reset && m_phase <= P_RUN && m_q.size() < DEPTH;
  endfunction

  task automatic model_step();
    bit          push, mism, at_limit;
    logic [36:0] head;
    push = exp_valid && m_ready();
    if (m_phase == P_HOLD) begin
      m_hold++;
      if (m_hold == RST_CYCLES) m_phase = P_RUN;
    end else if (m_phase == P_RUN) begin
      if (wb_valid) begin
        if (m_q.size() == 0) begin
          head = '0;
          mism = 1'b1;
        end else begin
          head = m_q.pop_front();
          mism = (head != {wb_addr, wb_data});
        end
        if (mism) begin
          if (m_mis == 0) begin
            m_faddr = head[36:32];
            m_fexp  = head[31:0];
            m_fgot  = wb_data;
          end
          if (m_mis < CNT_MAX) m_mis++;
        end
      end
      at_limit = (m_cycles == MAX_CYCLES - 1);
      if (m_cycles < CNT_MAX) m_cycles++;
      if (at_limit) m_phase = P_TIMEOUT;
      else if (end_of_test)
        m_phase = (m_mis == 0 && m_q.size() == 0 && !push) ? P_PASS : P_FAIL;
    end
    if (push) m_q.push_back({exp_addr, exp_data});
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = P_HOLD; m_hold = 0; m_cycles = 0; m_mis = 0;
      m_q.delete();
      m_faddr = '0; m_fexp = '0; m_fgot = '0;
    end else begin
      model_step();
    end
  end

  task automatic idle();
    exp_valid = 1'b0; exp_addr = '0; exp_data = '0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    end_of_test = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_one(input logic [4:0] a, input logic [DATA_W-1:0] d);
    exp_valid = 1'b1; exp_addr = a; exp_data = d;
  endtask

  task automatic wb_one(input logic [4:0] a, input logic [DATA_W-1:0] d);
    wb_valid = 1'b1; wb_addr = a; wb_data = d;
  endtask

  // Called on a falling edge; returns on the falling edge after the core enters RUN.
  task automatic do_reset(input bit noisy);
    idle();
    reset = 1'b0;
    #1;
    @(negedge clk);
    #1 reset = 1'b1;
    if (noisy) wb_one(5'($urandom), $urandom);
    @(negedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset();
    #20;
    n_checks++; if (core_rst_n !== 1'b0) begin n_errors++; $display("FAIL rst_core_rst_n: got %b expected 0", core_rst_n); end
    n_checks++; if (exp_ready !== 1'b0) begin n_errors++; $display("FAIL rst_exp_ready: got %b expected 0", exp_ready); end
    n_checks++; if ({done, pass, fail, timeout} !== 4'b0) begin n_errors++; $display("FAIL rst_flags: got %b expected 0000", {done, pass, fail, timeout}); end
    n_checks++; if (cycle_count !== '0 || mismatch_count !== '0) begin n_errors++; $display("FAIL rst_counts: got %0d/%0d expected 0/0", cycle_count, mismatch_count); end
    #105 reset = 1'b1;
    #1;
    n_checks++; if (exp_ready !== 1'b1) begin n_errors++; $display("FAIL rel_exp_ready: got %b expected 1", exp_ready); end
    @(negedge clk);
    n_checks++; if (core_rst_n !== 1'b0) begin n_errors++; $display("FAIL hold_edge1: got %b expected 0", core_rst_n); end
    @(negedge clk);
    n_checks++; if (core_rst_n !== 1'b1) begin n_errors++; $display("FAIL hold_edge2: got %b expected 1", core_rst_n); end
    n_checks++; if (cycle_count !== 16'd0) begin n_errors++; $display("FAIL run_start_count: got %0d expected 0", cycle_count); end
    step();
    n_checks++; if (cycle_count !== 16'd1) begin n_errors++; $display("FAIL run_count1: got %0d expected 1", cycle_count); end
  endtask

  task automatic test_pass();
    push_one(5'd3, 32'h0000_000C); step(); idle();
    wb_one(5'd3, 32'h0000_000C); step(); idle();
    n_checks++; if (mismatch_count !== '0) begin n_errors++; $display("FAIL pass_mis: got %0d expected 0", mismatch_count); end
    end_of_test = 1'b1; step(); idle();
    n_checks++; if ({done, pass, fail, timeout} !== 4'b1100) begin n_errors++; $display("FAIL pass_flags: got %b expected 1100", {done, pass, fail, timeout}); end
    n_checks++; if (core_rst_n !== 1'b0 || exp_ready !== 1'b0) begin n_errors++; $display("FAIL pass_rst_ready: got %b%b expected 00", core_rst_n, exp_ready); end
  endtask

  task automatic test_mismatch();
    do_reset(1'b0);
    push_one(5'd3, 32'h0000_000C); step(); idle();
    wb_one(5'd3, 32'h0000_0008); step(); idle();
    n_checks++; if (mismatch_count !== 16'd1) begin n_errors++; $display("FAIL mis_count: got %0d expected 1", mismatch_count); end
    n_checks++; if (fail_addr !== 5'd3 || fail_exp !== 32'hC || fail_got !== 32'h8) begin n_errors++; $display("FAIL mis_capture: got %0d/%h/%h expected 3/c/8", fail_addr, fail_exp, fail_got); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL mis_not_done: got %b expected 0", done); end
    wb_one(5'd7, 32'h0000_0005); step(); idle();
    n_checks++; if (mismatch_count !== 16'd2) begin n_errors++; $display("FAIL mis_count2: got %0d expected 2", mismatch_count); end
    n_checks++; if (fail_got !== 32'h8 || fail_addr !== 5'd3) begin n_errors++; $display("FAIL mis_first_only: got %0d/%h expected 3/8", fail_addr, fail_got); end
    end_of_test = 1'b1; step(); idle();
    n_checks++; if ({done, pass, fail, timeout} !== 4'b1010) begin n_errors++; $display("FAIL mis_flags: got %b expected 1010", {done, pass, fail, timeout}); end
  endtask

  task automatic test_empty_wb();
    do_reset(1'b0);
    push_one(5'd9, 32'h0000_00AB); wb_one(5'd9, 32'h0000_00AB); step(); idle();
    n_checks++; if (mismatch_count !== 16'd1) begin n_errors++; $display("FAIL nobypass_mis: got %0d expected 1", mismatch_count); end
    n_checks++; if (fail_addr !== '0 || fail_exp !== '0 || fail_got !== 32'hAB) begin n_errors++; $display("FAIL nobypass_cap: got %0d/%h/%h expected 0/0/ab", fail_addr, fail_exp, fail_got); end
    wb_one(5'd9, 32'h0000_00AB); step(); idle();
    n_checks++; if (mismatch_count !== 16'd1) begin n_errors++; $display("FAIL queued_match: got %0d expected 1", mismatch_count); end
    end_of_test = 1'b1; step(); idle();
    n_checks++; if (pass !== 1'b0 || fail !== 1'b1) begin n_errors++; $display("FAIL empty_verdict: got %b%b expected 01", pass, fail); end
  endtask

  task automatic test_eot_mismatch();
    do_reset(1'b0);
    push_one(5'd1, 32'h0000_0011); step(); idle();
    wb_one(5'd1, 32'h0000_0012); end_of_test = 1'b1; step(); idle();
    n_checks++; if (mismatch_count !== 16'd1) begin n_errors++; $display("FAIL eotmis_count: got %0d expected 1", mismatch_count); end
    n_checks++; if ({pass, fail} !== 2'b01) begin n_errors++; $display("FAIL eotmis_verdict: got %b expected 01", {pass, fail}); end
  endtask

  task automatic test_full_wrap();
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin push_one(5'($urandom), $urandom); step(); end
    idle();
    for (int i = 0; i < 5; i++) begin wb_valid = 1'b1; {wb_addr, wb_data} = m_q[0]; step(); end
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++; if (exp_ready !== 1'b1) begin n_errors++; $display("FAIL fill_ready%0d: got %b expected 1", i, exp_ready); end
      push_one(5'($urandom), $urandom); step();
    end
    idle();
    n_checks++; if (exp_ready !== 1'b0) begin n_errors++; $display("FAIL full_ready: got %b expected 0", exp_ready); end
    push_one(5'd30, 32'hDEAD_0001); wb_valid = 1'b1; {wb_addr, wb_data} = m_q[0];
    #1;
    n_checks++; if (exp_ready !== 1'b0) begin n_errors++; $display("FAIL full_pushpop_ready: got %b expected 0", exp_ready); end
    step(); idle();
    n_checks++; if (exp_ready !== 1'b1) begin n_errors++; $display("FAIL after_pop_ready: got %b expected 1", exp_ready); end
    push_one(5'd31, 32'hBEEF_0002); step(); idle();
    n_checks++; if (exp_ready !== 1'b0) begin n_errors++; $display("FAIL refill_ready: got %b expected 0", exp_ready); end
    for (int i = 0; i < DEPTH; i++) begin wb_valid = 1'b1; {wb_addr, wb_data} = m_q[0]; step(); end
    idle();
    n_checks++; if (mismatch_count !== '0) begin n_errors++; $display("FAIL wrap_mis: got %0d expected 0", mismatch_count); end
    end_of_test = 1'b1; step(); idle();
    n_checks++; if ({done, pass, fail} !== 3'b110) begin n_errors++; $display("FAIL wrap_pass: got %b expected 110", {done, pass, fail}); end
  endtask

  task automatic test_timeout();
    do_reset(1'b0);
    for (int i = 0; i < 200 && timeout !== 1'b1; i++) step();
    n_checks++; if ({done, pass, fail, timeout} !== 4'b1011) begin n_errors++; $display("FAIL to_flags: got %b expected 1011", {done, pass, fail, timeout}); end
    n_checks++; if (cycle_count !== 16'(MAX_CYCLES)) begin n_errors++; $display("FAIL to_cycle: got %0d expected %0d", cycle_count, MAX_CYCLES); end
    n_checks++; if (core_rst_n !== 1'b0) begin n_errors++; $display("FAIL to_core_rst: got %b expected 0", core_rst_n); end
    wb_one(5'd2, 32'h1); step(); step(); idle();
    n_checks++; if (cycle_count !== 16'(MAX_CYCLES) || mismatch_count !== '0) begin n_errors++; $display("FAIL to_frozen: got %0d/%0d expected %0d/0", cycle_count, mismatch_count, MAX_CYCLES); end
    do_reset(1'b0);
    for (int i = 0; i < 200 && m_cycles != MAX_CYCLES - 1; i++) step();
    end_of_test = 1'b1; step(); idle();
    n_checks++; if ({pass, fail, timeout} !== 3'b011) begin n_errors++; $display("FAIL to_priority: got %b expected 011", {pass, fail, timeout}); end
  endtask

  task automatic test_midrun_reset();
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin push_one(5'(i + 1), 32'h100 + i); step(); end
    idle(); step();
    #2 reset = 1'b0;
    #1;
    n_checks++; if ({core_rst_n, exp_ready, done, pass, fail, timeout} !== 6'b0) begin n_errors++; $display("FAIL mrst_bits: got %b expected 000000", {core_rst_n, exp_ready, done, pass, fail, timeout}); end
    n_checks++; if (cycle_count !== '0 || mismatch_count !== '0 || fail_got !== '0) begin n_errors++; $display("FAIL mrst_regs: got %0d/%0d/%h expected 0/0/0", cycle_count, mismatch_count, fail_got); end
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    n_checks++; if (core_rst_n !== 1'b0) begin n_errors++; $display("FAIL mrst_edge1: got %b expected 0", core_rst_n); end
    @(negedge clk);
    n_checks++; if (core_rst_n !== 1'b1 || exp_ready !== 1'b1) begin n_errors++; $display("FAIL mrst_edge2: got %b%b expected 11", core_rst_n, exp_ready); end
    end_of_test = 1'b1; step(); idle();
    n_checks++; if (pass !== 1'b1) begin n_errors++; $display("FAIL mrst_flushed: got pass=%b expected 1", pass); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      do_reset(1'b1);
      n_checks++; if (mismatch_count !== '0) begin n_errors++; $display("FAIL rnd_hold_ignore: got %0d expected 0", mismatch_count); end
      for (int i = 0; i < 50; i++) begin
        exp_valid = 1'($urandom_range(0, 1));
        exp_addr  = 5'($urandom_range(0, 3));
        exp_data  = 32'($urandom_range(0, 15));
        wb_valid  = ($urandom_range(0, 2) == 0);
        if (m_q.size() > 0 && $urandom_range(0, 3) != 0) {wb_addr, wb_data} = m_q[0];
        else begin wb_addr = 5'($urandom_range(0, 3)); wb_data = 32'($urandom_range(0, 15)); end
        step();
        n_checks++; if (cycle_count !== 16'(m_cycles)) begin n_errors++; $display("FAIL rnd_cycle: got %0d expected %0d", cycle_count, m_cycles); end
        n_checks++; if (mismatch_count !== 16'(m_mis)) begin n_errors++; $display("FAIL rnd_mis: got %0d expected %0d", mismatch_count, m_mis); end
        n_checks++; if (exp_ready !== m_ready()) begin n_errors++; $display("FAIL rnd_ready: got %b expected %b", exp_ready, m_ready()); end
        n_checks++; if ({fail_addr, fail_exp, fail_got} !== {m_faddr, m_fexp, m_fgot}) begin n_errors++; $display("FAIL rnd_capture: got %0d/%h/%h expected %0d/%h/%h", fail_addr, fail_exp, fail_got, m_faddr, m_fexp, m_fgot); end
      end
      idle();
      end_of_test = 1'b1; step(); idle();
      n_checks++; if (pass !== (m_phase == P_PASS) || fail !== (m_phase == P_FAIL || m_phase == P_TIMEOUT)) begin n_errors++; $display("FAIL rnd_verdict: got %b%b expected phase %0d", pass, fail, m_phase); end
      n_checks++; if (done !== (m_phase >= P_PASS) || core_rst_n !== (m_phase == P_RUN)) begin n_errors++; $display("FAIL rnd_done: got %b%b expected phase %0d", done, core_rst_n, m_phase); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_pass();
    test_mismatch();
    test_empty_wb();
    test_eot_mismatch();
    test_full_wrap();
    test_timeout();
    test_midrun_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
